// File: rtl/ef_spi_slave_pkg.sv
// ---------------------------------------------------------------------------
// ef_spi_slave_pkg
// Shared types and constants for the EF SPI target (slave).
//   state_e         : frame state (IDLE while csb high, ACTIVE while csb low)
//   DEF_DW          : default frame width
//   DEF_SYNC_STAGES : default synchronizer depth
//   UNDERRUN_FILL   : pattern shifted out when no TX byte is available
// ---------------------------------------------------------------------------
package ef_spi_slave_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_e;

    localparam int unsigned DEF_DW          = 8;
    localparam int unsigned DEF_SYNC_STAGES = 2;

    // Wide enough for any practical DW; users slice the low DW bits.
    localparam logic [63:0] UNDERRUN_FILL = {64{1'b1}};

endpackage

// File: rtl/ef_spi_slave_sync.sv
// ---------------------------------------------------------------------------
// ef_spi_slave_sync
// Multi-flop synchronizer for one asynchronous input, followed by a register
// holding the previous synchronized value so single-cycle rise/fall pulses
// can be derived in the clk domain.
// Ports:
//   clk, rst_n : system clock, asynchronous active-low reset
//   d          : asynchronous input pin
//   level      : synchronized level
//   rise, fall : one-cycle pulses on synchronized 0->1 / 1->0 transitions
// ---------------------------------------------------------------------------
module ef_spi_slave_sync #(
    parameter int unsigned STAGES  = 2,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain_q;
    logic [STAGES-1:0] chain_d;
    logic              prev_q;

    // Next value of the synchronizer chain: shift the pin in at bit 0.
    always_comb begin
        chain_d = {chain_q[STAGES-2:0], d};
    end

    // Synchronizer chain and previous-level register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_q <= {STAGES{RST_VAL}};
            prev_q  <= RST_VAL;
        end else begin
            chain_q <= chain_d;
            prev_q  <= chain_q[STAGES-1];
        end
    end

    assign level = chain_q[STAGES-1];
    assign rise  = chain_q[STAGES-1] & ~prev_q;
    assign fall  = ~chain_q[STAGES-1] & prev_q;

endmodule

// File: rtl/ef_spi_slave.sv
// ---------------------------------------------------------------------------
// ef_spi_slave
// SPI target oversampled in the clk domain (clk >= 4x SCLK). All four
// CPOL/CPHA modes, MSB first. Received bytes go to a valid/ready consumer;
// bytes to send come from a valid/ready producer through a one-deep holding
// register.
// Ports:
//   clk, rst_n          : system clock, asynchronous active-low reset
//   CPOL, CPHA          : SPI mode, static while csb is low
//   sclk, csb, sdi      : bus inputs from the master (asynchronous)
//   sdo, sdo_oe         : serial data to the master and its output enable
//   tx_data/valid/ready : producer handshake into the TX holding register
//   rx_data/valid/ready : received byte towards the consumer
//   busy                : frame in progress (synchronized csb low)
//   overrun, ovr_clr    : sticky RX overrun flag and its clear
// Build option: EF_SPI_SLAVE_OVR_EN adds overrun/ovr_clr; a byte completing
// while the previous one is still unconsumed is then dropped instead of
// overwriting rx_data.
// ---------------------------------------------------------------------------
module ef_spi_slave
    import ef_spi_slave_pkg::*;
#(
    parameter int unsigned DW          = DEF_DW,
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          CPOL,
    input  logic          CPHA,
    input  logic          sclk,
    input  logic          csb,
    input  logic          sdi,
    output logic          sdo,
    output logic          sdo_oe,
    input  logic [DW-1:0] tx_data,
    input  logic          tx_valid,
    output logic          tx_ready,
    output logic [DW-1:0] rx_data,
    output logic          rx_valid,
    input  logic          rx_ready,
`ifdef EF_SPI_SLAVE_OVR_EN
    output logic          busy,
    output logic          overrun,
    input  logic          ovr_clr
`else
    output logic          busy
`endif
);

    localparam int unsigned      CW   = (DW > 2) ? $clog2(DW) : 1;
    localparam logic [CW-1:0]    LAST = CW'(DW - 1);
    localparam logic [DW-1:0]    FILL = UNDERRUN_FILL[DW-1:0];

    logic sclk_s, sclk_rise_s, sclk_fall_s;
    logic csb_unused_lvl_s, csb_rise_s, csb_fall_s;
    logic sdi_s, sdi_rise_unused_s, sdi_fall_unused_s;

    ef_spi_slave_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .d(sclk),
        .level(sclk_s), .rise(sclk_rise_s), .fall(sclk_fall_s)
    );
    ef_spi_slave_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_csb (
        .clk(clk), .rst_n(rst_n), .d(csb),
        .level(csb_unused_lvl_s), .rise(csb_rise_s), .fall(csb_fall_s)
    );
    ef_spi_slave_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sdi (
        .clk(clk), .rst_n(rst_n), .d(sdi),
        .level(sdi_s), .rise(sdi_rise_unused_s), .fall(sdi_fall_unused_s)
    );

    state_e         state_q, state_d;
    logic [CW-1:0]  bit_cnt_q, bit_cnt_d;
    logic           load_q, load_d;
    logic [DW-1:0]  rx_shift_q, rx_shift_d;
    logic [DW-1:0]  tx_shift_q, tx_shift_d;
    logic [DW-1:0]  hold_q, hold_d;
    logic           hold_full_q, hold_full_d;
    logic [DW-1:0]  rx_data_q, rx_data_d;
    logic           rx_valid_q, rx_valid_d;
    logic           ovr_q, ovr_d;

    logic           lead_s, trail_s, sample_s, shift_s;
    logic           byte_done_s, tx_take_s;
    logic [DW-1:0]  rx_byte_s;

    // Leading edge leaves the idle level, trailing edge returns to it.
    assign lead_s   = CPOL ? sclk_fall_s : sclk_rise_s;
    assign trail_s  = CPOL ? sclk_rise_s : sclk_fall_s;
    assign sample_s = CPHA ? trail_s : lead_s;
    assign shift_s  = CPHA ? lead_s  : trail_s;
    assign rx_byte_s = {rx_shift_q[DW-2:0], sdi_s};

    // Frame state, bit counting, shift registers, TX holding and RX output.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        load_d      = load_q;
        rx_shift_d  = rx_shift_q;
        tx_shift_d  = tx_shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        ovr_d       = ovr_q;
        byte_done_s = 1'b0;
        tx_take_s   = 1'b0;

        case (state_q)
            IDLE: begin
                if (csb_fall_s) begin
                    state_d   = ACTIVE;
                    bit_cnt_d = '0;
                    // CPHA=0 must present bit 0 before the first SCLK edge;
                    // CPHA=1 waits for the first (leading) shift edge.
                    if (CPHA) begin
                        load_d = 1'b1;
                    end else begin
                        load_d    = 1'b0;
                        tx_take_s = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ACTIVE: begin
                if (csb_rise_s) begin
                    // Abort: drop any partial byte, holding register untouched.
                    state_d    = IDLE;
                    bit_cnt_d  = '0;
                    load_d     = 1'b0;
                    rx_shift_d = '0;
                end else begin
                    if (sample_s) begin
                        rx_shift_d = rx_byte_s;
                        if (bit_cnt_q == LAST) begin
                            bit_cnt_d   = '0;
                            load_d      = 1'b1;
                            byte_done_s = 1'b1;
                        end else begin
                            bit_cnt_d = bit_cnt_q + CW'(1);
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q;
                    end
                    if (shift_s) begin
                        if (load_q) begin
                            load_d    = 1'b0;
                            tx_take_s = 1'b1;
                        end else begin
                            tx_shift_d = {tx_shift_q[DW-2:0], 1'b0};
                        end
                    end else begin
                        tx_shift_d = tx_shift_q;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Load the TX shifter from the holding register, or the fill pattern.
        if (tx_take_s) begin
            tx_shift_d = hold_full_q ? hold_q : FILL;
        end else begin
            hold_d = hold_q;
        end

        // A full holding register cannot accept a write, so take and write
        // never act on the same byte.
        if (tx_take_s && hold_full_q) begin
            hold_full_d = 1'b0;
        end else if (tx_valid && !hold_full_q) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end else begin
            hold_full_d = hold_full_q;
        end

`ifdef EF_SPI_SLAVE_OVR_EN
        if (byte_done_s && rx_valid_q && !rx_ready) begin
            ovr_d = 1'b1;
        end else if (byte_done_s) begin
            rx_data_d  = rx_byte_s;
            rx_valid_d = 1'b1;
        end else if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end else begin
            rx_valid_d = rx_valid_q;
        end
        // Set takes priority over clear.
        if (byte_done_s && rx_valid_q && !rx_ready) begin
            ovr_d = 1'b1;
        end else if (ovr_clr) begin
            ovr_d = 1'b0;
        end else begin
            ovr_d = ovr_q;
        end
`else
        if (byte_done_s) begin
            rx_data_d  = rx_byte_s;
            rx_valid_d = 1'b1;
        end else if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end else begin
            rx_valid_d = rx_valid_q;
        end
        ovr_d = 1'b0;
`endif
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            load_q      <= 1'b0;
            rx_shift_q  <= '0;
            tx_shift_q  <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            load_q      <= load_d;
            rx_shift_q  <= rx_shift_d;
            tx_shift_q  <= tx_shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            ovr_q       <= ovr_d;
        end
    end

    assign busy     = (state_q == ACTIVE);
    assign sdo_oe   = (state_q == ACTIVE);
    assign sdo      = tx_shift_q[DW-1];
    assign tx_ready = ~hold_full_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
`ifdef EF_SPI_SLAVE_OVR_EN
    assign overrun  = ovr_q;
`endif

endmodule

// File: tb/tb_ef_spi_slave.sv
// ---------------------------------------------------------------------------
// tb_ef_spi_slave
// Bit-banged SPI master driving ef_spi_slave in all modes. A producer feeds
// tx bytes from a queue, a consumer collects handshaken rx bytes; expected
// values come from the protocol rules (master data arrives in order, an
// empty holding register yields 0xFF).
// ---------------------------------------------------------------------------
module tb_ef_spi_slave;

    localparam int DW   = 8;
    localparam int HALF = 8;

    logic clk = 1'b0;
    logic rst_n, CPOL, CPHA, sclk, csb, sdi, rx_ready;
    logic sdo, sdo_oe, tx_ready, rx_valid, busy;
    logic [DW-1:0] rx_data;
    logic [DW-1:0] tx_data  = '0;
    logic          tx_valid = 1'b0;
`ifdef EF_SPI_SLAVE_OVR_EN
    logic overrun, ovr_clr;
`endif

    int checks = 0;
    int errors = 0;
    logic [7:0] txq[$];
    logic [7:0] got[$];
    bit pend = 1'b0;
    bit txr_low_seen;

    typedef struct {
        bit cpol; bit cpha; int nb;
        logic [7:0] m0; logic [7:0] m1;
        bit pre; logic [7:0] t0; logic [7:0] t1;
        logic [7:0] e0; logic [7:0] e1;
    } vec_t;
    vec_t tbl[5];

    always #5 clk = ~clk;

    ef_spi_slave dut (
        .clk(clk), .rst_n(rst_n), .CPOL(CPOL), .CPHA(CPHA),
        .sclk(sclk), .csb(csb), .sdi(sdi), .sdo(sdo), .sdo_oe(sdo_oe),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
`ifdef EF_SPI_SLAVE_OVR_EN
        .busy(busy), .overrun(overrun), .ovr_clr(ovr_clr)
`else
        .busy(busy)
`endif
    );

    // Producer: present txq head; tx_ready seen at a negedge holds through
    // the next posedge, so the handshake outcome is known in advance.
    always @(negedge clk) begin
        if (!rst_n) begin
            pend     = 1'b0;
            tx_valid = 1'b0;
        end else begin
            if (pend) txq.delete(0);
            if (txq.size() > 0) begin
                tx_valid = 1'b1;
                tx_data  = txq[0];
            end else begin
                tx_valid = 1'b0;
            end
            pend = tx_valid && tx_ready;
        end
    end

    // Consumer: record bytes that will be accepted at the next posedge.
    always begin
        @(negedge clk);
        #1;
        if (rst_n && rx_valid && rx_ready) got.push_back(rx_data);
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) begin
            @(negedge clk);
            if (!tx_ready) txr_low_seen = 1'b1;
        end
    endtask

    task automatic wait_loaded();
        int n = 0;
        while (tx_ready && n < 50) begin
            wait_clk(1);
            n++;
        end
        chk("preload_tx_ready", {31'b0, tx_ready}, 32'd0);
    endtask

    task automatic spi_xfer(input bit cpol, input bit cpha, input int nbits,
                            input logic [23:0] mosi, input bit end_cs,
                            output logic [23:0] miso);
        miso = '0;
        CPOL = cpol; CPHA = cpha; sclk = cpol;
        wait_clk(4);
        csb = 1'b0;
        wait_clk(HALF);
        for (int i = 0; i < nbits; i++) begin
            if (!cpha) begin
                sdi = mosi[nbits-1-i];
                wait_clk(HALF);
                miso = {miso[22:0], sdo};
                sclk = ~cpol;
                wait_clk(HALF);
                sclk = cpol;
            end else begin
                sclk = ~cpol;
                sdi  = mosi[nbits-1-i];
                wait_clk(HALF);
                miso = {miso[22:0], sdo};
                sclk = cpol;
                wait_clk(HALF);
            end
        end
        wait_clk(HALF);
        if (end_cs) begin
            csb = 1'b1;
            wait_clk(HALF);
        end
    endtask

    task automatic run_case(input string tag, input bit cpol, input bit cpha, input int nb,
                            input logic [7:0] m0, input logic [7:0] m1, input bit pre,
                            input logic [7:0] t0, input logic [7:0] t1,
                            input logic [7:0] e0, input logic [7:0] e1);
        logic [23:0] mosi, miso;
        got.delete();
        txr_low_seen = 1'b0;
        if (pre) begin
            txq.push_back(t0);
            if (nb > 1) txq.push_back(t1);
            wait_loaded();
        end
        mosi = (nb > 1) ? {8'h00, m0, m1} : {16'h0000, m0};
        spi_xfer(cpol, cpha, nb * 8, mosi, 1'b1, miso);
        chk({tag, "_rx_count"}, got.size(), nb);
        if (got.size() > 0) chk({tag, "_rx0"}, {24'h0, got[0]}, {24'h0, m0});
        if (nb > 1 && got.size() > 1) chk({tag, "_rx1"}, {24'h0, got[1]}, {24'h0, m1});
        if (nb > 1) begin
            chk({tag, "_miso0"}, {24'h0, miso[15:8]}, {24'h0, e0});
            chk({tag, "_miso1"}, {24'h0, miso[7:0]}, {24'h0, e1});
        end else begin
            chk({tag, "_miso0"}, {24'h0, miso[7:0]}, {24'h0, e0});
        end
        chk({tag, "_tx_drained"}, txq.size(), 0);
        chk({tag, "_tx_ready_low"}, {31'b0, txr_low_seen}, {31'b0, pre});
    endtask

    initial begin
        logic [23:0] miso;
        bit rc, rp, rpre;
        int rnb;
        logic [7:0] r0, r1, s0, s1;

        rst_n = 1'b0; CPOL = 1'b0; CPHA = 1'b0; sclk = 1'b0; csb = 1'b1;
        sdi = 1'b0; rx_ready = 1'b1;
`ifdef EF_SPI_SLAVE_OVR_EN
        ovr_clr = 1'b0;
`endif
        tbl[0] = '{1'b0, 1'b0, 1, 8'h3C, 8'h00, 1'b1, 8'hA5, 8'h00, 8'hA5, 8'h00};
        tbl[1] = '{1'b0, 1'b1, 2, 8'hF0, 8'h0F, 1'b1, 8'h12, 8'h34, 8'h12, 8'h34};
        tbl[2] = '{1'b1, 1'b0, 2, 8'hF0, 8'h0F, 1'b1, 8'h12, 8'h34, 8'h12, 8'h34};
        tbl[3] = '{1'b1, 1'b1, 2, 8'hF0, 8'h0F, 1'b1, 8'h12, 8'h34, 8'h12, 8'h34};
        tbl[4] = '{1'b0, 1'b0, 1, 8'h5A, 8'h00, 1'b0, 8'h00, 8'h00, 8'hFF, 8'h00};

        wait_clk(3);
        chk("rst_sdo", {31'b0, sdo}, 32'd0);
        chk("rst_sdo_oe", {31'b0, sdo_oe}, 32'd0);
        chk("rst_tx_ready", {31'b0, tx_ready}, 32'd1);
        chk("rst_rx_data", {24'h0, rx_data}, 32'd0);
        chk("rst_rx_valid", {31'b0, rx_valid}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
`ifdef EF_SPI_SLAVE_OVR_EN
        chk("rst_overrun", {31'b0, overrun}, 32'd0);
`endif
        rst_n = 1'b1;
        wait_clk(4);

        for (int i = 0; i < 5; i++) begin
            run_case($sformatf("vec%0d", i), tbl[i].cpol, tbl[i].cpha, tbl[i].nb,
                     tbl[i].m0, tbl[i].m1, tbl[i].pre, tbl[i].t0, tbl[i].t1,
                     tbl[i].e0, tbl[i].e1);
        end

        for (int i = 0; i < 8; i++) begin
            rc = 1'($urandom_range(0, 1)); rp = 1'($urandom_range(0, 1));
            rpre = 1'($urandom_range(0, 1)); rnb = $urandom_range(1, 2);
            r0 = 8'($urandom); r1 = 8'($urandom);
            s0 = 8'($urandom); s1 = 8'($urandom);
            run_case($sformatf("rnd%0d", i), rc, rp, rnb, r0, r1, rpre, s0, s1,
                     rpre ? s0 : 8'hFF, rpre ? s1 : 8'hFF);
        end

        // Aborted frame after 5 bits, then a complete byte.
        got.delete();
        spi_xfer(1'b0, 1'b0, 5, 24'h000015, 1'b1, miso);
        chk("partial_no_rx", got.size(), 0);
        chk("partial_rx_valid", {31'b0, rx_valid}, 32'd0);
        run_case("after_partial", 1'b0, 1'b0, 1, 8'h81, 8'h00, 1'b0, 8'h00, 8'h00, 8'hFF, 8'h00);

        // Two bytes with the consumer stalled.
        rx_ready = 1'b0;
        got.delete();
        spi_xfer(1'b0, 1'b0, 16, 24'h001122, 1'b1, miso);
        chk("stall_rx_valid", {31'b0, rx_valid}, 32'd1);
`ifdef EF_SPI_SLAVE_OVR_EN
        chk("stall_rx_data", {24'h0, rx_data}, 32'h11);
        chk("stall_overrun", {31'b0, overrun}, 32'd1);
        ovr_clr = 1'b1;
        wait_clk(1);
        ovr_clr = 1'b0;
        wait_clk(1);
        chk("ovr_cleared", {31'b0, overrun}, 32'd0);
        s0 = 8'h11;
`else
        chk("stall_rx_data", {24'h0, rx_data}, 32'h22);
        s0 = 8'h22;
`endif
        rx_ready = 1'b1;
        wait_clk(3);
        chk("stall_drain_count", got.size(), 1);
        if (got.size() > 0) chk("stall_drain_data", {24'h0, got[0]}, {24'h0, s0});
        chk("stall_rx_valid_clr", {31'b0, rx_valid}, 32'd0);

        // Reset in the middle of a frame, with RX and TX state populated.
        rx_ready = 1'b0;
        got.delete();
        txq.push_back(8'h5A); txq.push_back(8'hC3); txq.push_back(8'hE7);
        wait_loaded();
        spi_xfer(1'b0, 1'b0, 12, 24'h00096A, 1'b0, miso);
        chk("mid_busy", {31'b0, busy}, 32'd1);
        chk("mid_sdo_oe", {31'b0, sdo_oe}, 32'd1);
        chk("mid_rx_valid", {31'b0, rx_valid}, 32'd1);
        chk("mid_rx_data", {24'h0, rx_data}, 32'h96);
        chk("mid_tx_ready", {31'b0, tx_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("arst_sdo", {31'b0, sdo}, 32'd0);
        chk("arst_sdo_oe", {31'b0, sdo_oe}, 32'd0);
        chk("arst_tx_ready", {31'b0, tx_ready}, 32'd1);
        chk("arst_rx_data", {24'h0, rx_data}, 32'd0);
        chk("arst_rx_valid", {31'b0, rx_valid}, 32'd0);
        chk("arst_busy", {31'b0, busy}, 32'd0);
        csb = 1'b1;
        wait_clk(3);
        rst_n = 1'b1;
        rx_ready = 1'b1;
        wait_clk(4);
        chk("arst_txq_consumed", txq.size(), 0);
        run_case("post_rst", 1'b0, 1'b0, 1, 8'hC3, 8'h00, 1'b0, 8'h00, 8'h00, 8'hFF, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ef_spi_slave.md
# ef_spi_slave

SPI target (slave) that is the far end of the EF_SPI master link. It accepts SCLK/CSB/SDI from an external master, deserializes received bytes toward a local consumer and serializes bytes from a local producer onto SDO. All bus inputs are oversampled in the `clk` domain, so no logic runs on SCLK. Supports all four CPOL/CPHA modes, MSB first.

## Interface
- `DW`, 8, frame width in bits (≥2)
- `SYNC_STAGES`, 2, synchronizer depth on sclk/csb/sdi (≥2)

- `clk` in 1 — system clock; must be ≥ 4× SCLK frequency
- `rst_n` in 1 — asynchronous active-low reset
- `CPOL` in 1 — SCLK idle level; static while csb low
- `CPHA` in 1 — 0: sample leading edge; 1: sample trailing edge; static while csb low
- `sclk` in 1 — serial clock from master
- `csb` in 1 — chip select, active low
- `sdi` in 1 — serial data from master
- `sdo` out 1 — serial data to master
- `sdo_oe` out 1 — SDO output enable, high while selected
- `tx_data` in DW — next byte to transmit
- `tx_valid` in 1 — producer has tx_data
- `tx_ready` out 1 — TX holding register empty
- `rx_data` out DW — received byte
- `rx_valid` out 1 — rx_data holds an unconsumed byte
- `rx_ready` in 1 — consumer accepts rx_data
- `busy` out 1 — frame in progress (synchronized csb low)
- `overrun` out 1 — sticky RX overrun flag (only with macro)
- `ovr_clr` in 1 — clears overrun (only with macro)

## Operation
- Reset values: sdo=0, sdo_oe=0, tx_ready=1, rx_data=0, rx_valid=0, busy=0, overrun=0; bit counter, shift registers, holding register cleared.
- States: IDLE (csb_s high), ACTIVE (csb_s low). IDLE→ACTIVE on csb_s fall; any→IDLE on csb_s rise.
- Edges: leading = sclk_s transition away from CPOL, trailing = back to CPOL. Sample edge = leading if CPHA=0 else trailing; shift edge = the other.
- Sample edge: rx_shift <= {rx_shift[DW-2:0], sdi_s}; bit counter +1, wraps mod DW. On the DW-th sample: byte complete, load flag set.
- TX load: tx_shift <= holding register if full (holding becomes empty, tx_ready=1) else all-ones (underrun fill). CPHA=0: load on csb_s fall, then on first shift edge after byte complete. CPHA=1: load on first shift edge of each byte (load flag set at csb_s fall). Other shift edges: tx_shift <<= 1. sdo = tx_shift[DW-1].
- TX holding: tx_valid && tx_ready writes tx_data, tx_ready drops next cycle. Writes accepted in any state.
- RX: on byte complete, rx_data <= assembled byte, rx_valid=1; cleared on rx_valid && rx_ready. Completion and acceptance in the same cycle: new byte loaded, rx_valid stays 1.
- csb_s rise mid-byte: partial byte discarded, bit counter and load flag cleared, no rx_valid, holding register untouched.
- sdo_oe = busy.

## Timing
- Input latency: SYNC_STAGES cycles plus 1 for edge detect; rx_valid rises SYNC_STAGES+1 cycles after the DW-th sample edge on the pin.
- SDO update: SYNC_STAGES+2 cycles after the shift edge (or csb fall); master must allow this before its sample edge.
- SCLK high and low times each ≥ 2 clk periods; csb setup to first SCLK edge ≥ SYNC_STAGES+2 clk.
- tx_ready/rx_valid are registered; back-to-back handshakes on consecutive cycles allowed.

## Configuration
- `EF_SPI_SLAVE_OVR_EN` defined: byte completing while rx_valid=1 and rx_ready=0 is dropped (rx_data keeps old byte) and overrun sets; overrun clears on ovr_clr; set wins over clear in the same cycle. Ports overrun/ovr_clr exist.
- Undefined: new byte overwrites rx_data, rx_valid stays 1; overrun/ovr_clr ports absent.

## Structure
- Package `ef_spi_slave_pkg`: state enum (IDLE, ACTIVE), default DW, all-ones underrun fill constant.
- Sub-module `ef_spi_slave_sync`: SYNC_STAGES flop chain for one input plus registered previous value giving rise/fall pulses; instantiated for sclk, csb, sdi (sdi uses level only).

## Test plan
- Mode 0, tx 0xA5 preloaded, master sends 0x3C → rx_data=0x3C with rx_valid once, master receives 0xA5.
- Modes 1/2/3 each, 2-byte burst under one csb, tx 0x12,0x34, master sends 0xF0,0x0F → both bytes correct each direction, two rx_valid events.
- No tx preloaded, mode 0 → master receives 0xFF; tx_ready stays 1.
- csb deasserted after 5 bits, then full frame 0x81 → no rx_valid for partial, next rx_data=0x81.
- rx_ready held 0 across two bytes 0x11,0x22 → with macro rx_data=0x11, overrun=1, cleared by ovr_clr; without macro rx_data=0x22.
- rst_n asserted mid-frame → all outputs at reset values immediately, next frame received correctly.
